// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and coin constants for the change dispenser
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAN,
    FIRE,
    WAIT,
    DONE,
    FAULT
  } dispense_state_t;

  localparam int COIN_NICKEL = 5;
  localparam int COIN_DIME   = 10;

endpackage

// File: rtl/change_planner.sv
// rtl/change_planner.sv - greedy dime-first coin plan and feasibility check
module change_planner
  import vend_pkg::*;
#(
  parameter int N     = 6,
  parameter int INV_W = 8,
  parameter int PW    = 9
) (
  input  logic [N-1:0]     amt,
  input  logic [INV_W-1:0] nickel_cnt,
  input  logic [INV_W-1:0] dime_cnt,
  output logic             feasible,
  output logic [PW-1:0]    dimes_needed,
  output logic [PW-1:0]    nickels_needed
);

  localparam logic [PW-1:0] DIME_W   = PW'(COIN_DIME);
  localparam logic [PW-1:0] NICKEL_W = PW'(COIN_NICKEL);

  logic [PW-1:0] amt_w;
  logic [PW-1:0] max_dimes;
  logic [PW-1:0] remainder;

  // Use as many dimes as stock allows, cover the rest with nickels.
  always_comb begin
    amt_w          = PW'(amt);
    max_dimes      = amt_w / DIME_W;
    dimes_needed   = (max_dimes < PW'(dime_cnt)) ? max_dimes : PW'(dime_cnt);
    remainder      = amt_w - dimes_needed * DIME_W;
    nickels_needed = remainder / NICKEL_W;
    feasible       = (nickels_needed <= PW'(nickel_cnt));
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// rtl/change_dispense_ctrl.sv - coin hopper sequencer with inventory counters
module change_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int N           = 6,
  parameter int INV_W       = 8,
  parameter int NICKEL_INIT = 20,
  parameter int DIME_INIT   = 20,
  parameter int TIMEOUT     = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N-1:0]     req_amount,
  input  logic             coin_done,
  input  logic             load_nickel,
  input  logic             load_dime,
  output logic             nickel_pulse,
  output logic             dime_pulse,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [INV_W-1:0] nickel_cnt,
  output logic [INV_W-1:0] dime_cnt
);

  localparam int PW = ((N > INV_W) ? N : INV_W) + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [N-1:0]     NICKEL_N = N'(COIN_NICKEL);
  localparam logic [INV_W-1:0] INV_MAX  = '1;

  dispense_state_t state, next_state;

  logic [N-1:0]  amt_q;
  logic [PW-1:0] dimes_left;
  logic [PW-1:0] nickels_left;
  logic [TW-1:0] wait_cnt;
  logic          fault_q;

  logic          plan_feasible;
  logic [PW-1:0] plan_dimes;
  logic [PW-1:0] plan_nickels;

  logic accept;
  logic fire_dime;
  logic fire_nickel;
  logic timed_out;
  logic coins_remain;

  assign accept       = req_valid && (state == IDLE);
  assign fire_dime    = (state == FIRE) && (dimes_left != '0);
  assign fire_nickel  = (state == FIRE) && (dimes_left == '0);
  assign timed_out    = (wait_cnt == TW'(TIMEOUT - 1));
  assign coins_remain = (dimes_left != '0) || (nickels_left != '0);

  change_planner #(
    .N     (N),
    .INV_W (INV_W),
    .PW    (PW)
  ) u_planner (
    .amt            (amt_q),
    .nickel_cnt     (nickel_cnt),
    .dime_cnt       (dime_cnt),
    .feasible       (plan_feasible),
    .dimes_needed   (plan_dimes),
    .nickels_needed (plan_nickels)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept) next_state = PLAN;
      PLAN: begin
        if (!plan_feasible)                              next_state = FAULT;
        else if ((plan_dimes == '0) && (plan_nickels == '0)) next_state = DONE;
        else                                             next_state = FIRE;
      end
      FIRE:  next_state = WAIT;
      WAIT: begin
        if (coin_done)      next_state = coins_remain ? FIRE : DONE;
        else if (timed_out) next_state = FAULT;
      end
      DONE:    next_state = IDLE;
      FAULT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request datapath: latched amount, coins still owed, wait timer, sticky fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      amt_q        <= '0;
      dimes_left   <= '0;
      nickels_left <= '0;
      wait_cnt     <= '0;
      fault_q      <= 1'b0;
    end else begin
      if (accept) begin
        amt_q   <= req_amount - (req_amount % NICKEL_N);
        fault_q <= 1'b0;
      end
      if (next_state == FAULT) fault_q <= 1'b1;
      if ((state == PLAN) && plan_feasible) begin
        dimes_left   <= plan_dimes;
        nickels_left <= plan_nickels;
      end
      if (fire_dime)   dimes_left   <= dimes_left - PW'(1);
      if (fire_nickel) nickels_left <= nickels_left - PW'(1);
      if (state == FIRE)      wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + TW'(1);
    end
  end

  // Inventory: restock saturates, an eject in the same cycle cancels a restock.
  always_ff @(posedge clk) begin
    if (reset) begin
      nickel_cnt <= INV_W'(NICKEL_INIT);
      dime_cnt   <= INV_W'(DIME_INIT);
    end else begin
      case ({load_nickel, fire_nickel})
        2'b10:   if (nickel_cnt != INV_MAX) nickel_cnt <= nickel_cnt + INV_W'(1);
        2'b01:   nickel_cnt <= nickel_cnt - INV_W'(1);
        default: nickel_cnt <= nickel_cnt;
      endcase
      case ({load_dime, fire_dime})
        2'b10:   if (dime_cnt != INV_MAX) dime_cnt <= dime_cnt + INV_W'(1);
        2'b01:   dime_cnt <= dime_cnt - INV_W'(1);
        default: dime_cnt <= dime_cnt;
      endcase
    end
  end

  // Moore output decode.
  always_comb begin
    req_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    dime_pulse   = 1'b0;
    nickel_pulse = 1'b0;
    fault        = fault_q;
    req_ready    = (state == IDLE);
    busy         = (state != IDLE);
    done         = (state == DONE);
    dime_pulse   = fire_dime;
    nickel_pulse = fire_nickel;
  end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// tb/tb_change_dispense_ctrl.sv - scoreboard bench for change_dispense_ctrl
module tb_change_dispense_ctrl;

  localparam int N           = 6;
  localparam int INV_W       = 8;
  localparam int NICKEL_INIT = 20;
  localparam int DIME_INIT   = 20;
  localparam int TIMEOUT     = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [N-1:0]     req_amount = '0;
  logic             coin_done = 1'b0;
  logic             load_nickel = 1'b0;
  logic             load_dime = 1'b0;
  logic             nickel_pulse;
  logic             dime_pulse;
  logic             busy;
  logic             done;
  logic             fault;
  logic [INV_W-1:0] nickel_cnt;
  logic [INV_W-1:0] dime_cnt;

  int  vectors = 0;
  int  miscompares = 0;
  int  nick_m;
  int  dime_m;
  byte exp_q[$];

  always #5 clk = ~clk;

  change_dispense_ctrl #(
    .N           (N),
    .INV_W       (INV_W),
    .NICKEL_INIT (NICKEL_INIT),
    .DIME_INIT   (DIME_INIT),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_amount   (req_amount),
    .coin_done    (coin_done),
    .load_nickel  (load_nickel),
    .load_dime    (load_dime),
    .nickel_pulse (nickel_pulse),
    .dime_pulse   (dime_pulse),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .nickel_cnt   (nickel_cnt),
    .dime_cnt     (dime_cnt)
  );

  task automatic do_request(input string name, input int amt, input bit ack, input bit load_in_fire);
    int  a, d, n, coins, cyc, loads, done_cnt, done_idx, fault_idx, first_pulse, fin_idx;
    int  exp_left, exp_done, exp_fault_idx, exp_first, exp_done_idx;
    bit  feas, fin, prev_pulse, exp_fault;
    byte got, e;
    a = amt - (amt % 5);
    d = a / 10;
    if (d > dime_m) d = dime_m;
    n = (a - 10 * d) / 5;
    feas = (n <= nick_m);
    coins = feas ? d + n : 0;
    exp_q.delete();
    if (feas) begin
      repeat (d) exp_q.push_back("D");
      repeat (n) exp_q.push_back("N");
    end
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_before got=%b exp=1", name, req_ready);
    end
    req_valid  = 1'b1;
    req_amount = amt[N-1:0];
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; loads = 0; done_cnt = 0; done_idx = -1; fault_idx = -1;
    first_pulse = -1; fin = 1'b0; fin_idx = -1; prev_pulse = 1'b0;
    while (!fin && cyc < 200) begin
      if (cyc > 1) @(negedge clk);
      load_nickel = 1'b0;
      coin_done   = ack && prev_pulse;
      prev_pulse  = dime_pulse || nickel_pulse;
      if (dime_pulse || nickel_pulse) begin
        if (first_pulse < 0) first_pulse = cyc;
        got = dime_pulse ? "D" : "N";
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL %s unexpected_pulse got=%c exp=none at cycle %0d", name, got, cyc);
        end else begin
          e = exp_q.pop_front();
          if (got !== e || (dime_pulse && nickel_pulse)) begin
            miscompares++;
            $display("FAIL %s pulse_order got=%c exp=%c at cycle %0d", name, got, e, cyc);
          end
        end
        if (load_in_fire && nickel_pulse) begin
          load_nickel = 1'b1;
          loads++;
        end
      end
      if (done) begin
        done_cnt++;
        done_idx = cyc;
      end
      if (fault && fault_idx < 0) fault_idx = cyc;
      if (!busy) begin
        fin = 1'b1;
        fin_idx = cyc;
      end
      cyc++;
    end
    coin_done   = 1'b0;
    load_nickel = 1'b0;

    exp_fault = !feas || (!ack && coins > 0);
    exp_left  = (feas && !ack && coins > 0) ? coins - 1 : 0;
    exp_done  = exp_fault ? 0 : 1;
    exp_first = (coins > 0) ? 2 : -1;
    exp_done_idx  = exp_fault ? -1 : 2 * coins + 2;
    exp_fault_idx = !feas ? 2 : ((!ack && coins > 0) ? 2 + TIMEOUT + 1 : -1);
    if (feas) begin
      if (ack) begin
        dime_m = dime_m - d;
        nick_m = nick_m - n + loads;
      end else if (coins > 0) begin
        if (d > 0) dime_m = dime_m - 1;
        else       nick_m = nick_m - 1 + loads;
      end
    end

    vectors++;
    if (!fin) begin
      miscompares++;
      $display("FAIL %s return_to_idle got=busy exp=idle within 200 cycles", name);
    end
    vectors++;
    if (exp_q.size() != exp_left) begin
      miscompares++;
      $display("FAIL %s pulses_missing got=%0d exp=%0d", name, exp_q.size(), exp_left);
    end
    vectors++;
    if (done_cnt != exp_done || done_idx != exp_done_idx) begin
      miscompares++;
      $display("FAIL %s done got=%0d@%0d exp=%0d@%0d", name, done_cnt, done_idx, exp_done, exp_done_idx);
    end
    vectors++;
    if (fault_idx != exp_fault_idx || fault !== exp_fault) begin
      miscompares++;
      $display("FAIL %s fault got=%b@%0d exp=%b@%0d", name, fault, fault_idx, exp_fault, exp_fault_idx);
    end
    vectors++;
    if (first_pulse != exp_first) begin
      miscompares++;
      $display("FAIL %s first_pulse_cycle got=%0d exp=%0d", name, first_pulse, exp_first);
    end
    vectors++;
    if (fin && req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_after got=%b exp=1 at cycle %0d", name, req_ready, fin_idx);
    end
    vectors++;
    if (nickel_cnt !== INV_W'(nick_m) || dime_cnt !== INV_W'(dime_m)) begin
      miscompares++;
      $display("FAIL %s counts got=n%0d/d%0d exp=n%0d/d%0d", name, nickel_cnt, dime_cnt, nick_m, dime_m);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    nick_m = NICKEL_INIT;
    dime_m = DIME_INIT;
    vectors++;
    if ({req_ready, busy, done, fault, dime_pulse, nickel_pulse} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b exp=100000", {req_ready, busy, done, fault, dime_pulse, nickel_pulse});
    end
    vectors++;
    if (nickel_cnt !== INV_W'(NICKEL_INIT) || dime_cnt !== INV_W'(DIME_INIT)) begin
      miscompares++;
      $display("FAIL reset_counts got=n%0d/d%0d exp=n%0d/d%0d", nickel_cnt, dime_cnt, NICKEL_INIT, DIME_INIT);
    end
  endtask

  task automatic test_basic();
    do_request("basic_25", 25, 1'b1, 1'b0);
  endtask

  task automatic test_drain();
    do_request("drain_60a", 60, 1'b1, 1'b0);
    do_request("drain_60b", 60, 1'b1, 1'b0);
    do_request("drain_60c", 60, 1'b1, 1'b0);
    do_request("nickels_60", 60, 1'b1, 1'b0);
    do_request("nickels_20", 20, 1'b1, 1'b0);
  endtask

  task automatic test_zero();
    do_request("zero", 0, 1'b1, 1'b0);
  endtask

  task automatic test_round_down();
    do_request("round_17", 17, 1'b1, 1'b0);
  endtask

  task automatic test_infeasible();
    @(negedge clk);
    load_dime = 1'b1;
    load_nickel = 1'b1;
    @(negedge clk);
    load_dime = 1'b0;
    @(negedge clk);
    load_nickel = 1'b0;
    dime_m += 1;
    nick_m += 2;
    vectors++;
    if (nickel_cnt !== INV_W'(nick_m) || dime_cnt !== INV_W'(dime_m)) begin
      miscompares++;
      $display("FAIL restock got=n%0d/d%0d exp=n%0d/d%0d", nickel_cnt, dime_cnt, nick_m, dime_m);
    end
    do_request("infeasible_30", 30, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    vectors++;
    if (fault !== 1'b1) begin
      miscompares++;
      $display("FAIL fault_sticky got=%b exp=1", fault);
    end
    do_request("clear_10", 10, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    req_valid = 1'b1;
    req_amount = N'(5);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (nickel_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_pulse got=%b exp=1", nickel_pulse);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nick_m = NICKEL_INIT;
    dime_m = DIME_INIT;
    vectors++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || nickel_cnt !== INV_W'(NICKEL_INIT) || dime_cnt !== INV_W'(DIME_INIT)) begin
      miscompares++;
      $display("FAIL reset_mid_state got=busy%b/ready%b/n%0d/d%0d exp=busy0/ready1/n%0d/d%0d",
               busy, req_ready, nickel_cnt, dime_cnt, NICKEL_INIT, DIME_INIT);
    end
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (nickel_pulse || dime_pulse) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_pulse got=%0d exp=0", pulses);
    end
  endtask

  task automatic test_timeout();
    do_request("timeout_10", 10, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_request("b2b_15", 15, 1'b1, 1'b0);
    do_request("b2b_35", 35, 1'b1, 1'b0);
  endtask

  task automatic test_restock_in_fire();
    do_request("load_in_fire", 5, 1'b1, 1'b1);
  endtask

  task automatic test_saturate();
    @(negedge clk);
    load_nickel = 1'b1;
    load_dime = 1'b1;
    repeat (260) @(negedge clk);
    load_nickel = 1'b0;
    load_dime = 1'b0;
    nick_m = 255;
    dime_m = 255;
    vectors++;
    if (nickel_cnt !== 8'd255 || dime_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL saturate got=n%0d/d%0d exp=n255/d255", nickel_cnt, dime_cnt);
    end
    do_request("after_saturate_15", 15, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drain();
    test_zero();
    test_round_down();
    test_infeasible();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    test_restock_in_fire();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
